muldiv_seq: RTL
===============

# muldiv_seq

Parametrised multi-cycle integer multiply/divide unit for the MIPS datapath, serving MULT, MULTU, DIV and DIVU. It extends the fixed 32-bit signed Booth multiplier with:
- a `WIDTH` parameter
- unsigned modes and restoring division
- a busy/done handshake and divide-by-zero flag.

It sits beside the ALU and writes the HI/LO register pair.

## Interface
- `WIDTH`, default 32: operand width. Legal values are even and ≥4. HI and LO are each `WIDTH` bits.
- `clk`  in  1  clock. All state updates on the falling edge, matching the datapath.
- `rst`  in  1  reset, synchronous and active-low (sampled on the falling edge of `clk`).
- `start`  in  1  request. Accepted only in IDLE.
- `op`  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU. Sampled with `start`.
- `A`  in  `WIDTH`  multiplicand / dividend. Sampled with `start`.
- `B`  in  `WIDTH`  multiplier / divisor. Sampled with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `hi`/`lo` updated on the same edge.
- `div_zero`  out  1  last completed DIV/DIVU had B==0. Valid from `done` until the next `done`.
- `hi`  out  `WIDTH`  product upper half / remainder.
- `lo`  out  `WIDTH`  product lower half / quotient.

## Operation
- State machine: IDLE → CALC → FINISH → IDLE.
  - **IDLE:** on `start`==1, latch `op`, `A` and `B` into internal registers; clear step counter; go to CALC. `busy`=1 from this edge.
  - **CALC:** one iteration per cycle, exactly `WIDTH` iterations, then go to FINISH.
  - **FINISH:** apply sign correction, write `hi`/`lo`/`div_zero`, assert `done`=1, `busy`=0, return to IDLE.
- **Multiply:**
  - Algorithm is radix-2 Booth over `WIDTH`+1-bit sign/zero-extended operands. Sign extension for MULT, zero extension for MULTU.
  - Result is the exact 2·`WIDTH`-bit product: {`hi`,`lo`}.
  - No overflow; all input combinations are exact.
- **Divide:**
  - Algorithm is restoring division on magnitudes (DIV takes absolute values; DIVU uses raw values).
  - `lo` = quotient, truncated toward zero. `hi` = remainder, whose sign follows the dividend.
  - Signed quotient is negated in FINISH when sign(A)≠sign(B). Remainder is negated when A<0.
  - Signed MIN/−1: `lo`=MIN (wraps), `hi`=0, no flag.
- **Divide by zero (B==0):**
  - Latency is unchanged.
  - Results: `hi`=A, `lo`=all ones, `div_zero`=1.
  - Multiply ops always set `div_zero`=0.
- `start` while `busy`: ignored. Latched operands are unaffected and no request is queued.
- Inputs `A`, `B` and `op` may change freely after the accepting edge.
- `hi`/`lo` hold their value between `done` pulses.

## Timing
- Reset (`rst`==0 at a falling edge):
  - State → IDLE, counter cleared.
  - `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0.
  - Any operation in progress is aborted with no `done`.
  - Reset wins over a simultaneous `start`.
- Latency: accept edge = edge 0. `done`=1 and results valid after edge `WIDTH`+1 (edge 33 for `WIDTH`=32). `done` is low after edge `WIDTH`+2.
- `busy` is high after edges 0 … `WIDTH` and low after edge `WIDTH`+1.
- Back-to-back: `start` sampled on edge `WIDTH`+1 is not accepted, because the state is still FINISH at that edge. The earliest accept is edge `WIDTH`+2, while `done` is high. Throughput is one operation per `WIDTH`+2 cycles.
- Counter: ⌈log2(`WIDTH`)⌉ bits. The FINISH transition occurs on the edge completing iteration `WIDTH`−1 and must not rely on counter wrap.

## Test plan
- **MULT, WIDTH=32:** A=−3, B=7 → `done` after edge 33 only. `hi`=FFFFFFFF, `lo`=FFFFFFEB, `div_zero`=0. `busy` high after edges 0–32.
- **MULTU:** A=B=FFFFFFFF → `hi`=FFFFFFFE, `lo`=00000001. Same operands under MULT → `hi`=0, `lo`=1.
- **DIV:**
  - −7/2 → `lo`=FFFFFFFD, `hi`=FFFFFFFF.
  - 80000000/FFFFFFFF → `lo`=80000000, `hi`=0.
  - DIVU 7/2 → `lo`=3, `hi`=1.
- **DIVU 7/0:** `div_zero`=1, `hi`=7, `lo`=FFFFFFFF, `done` after edge 33. A following MULT clears `div_zero` at its `done`.
- **Handshake:**
  - `start` with A=5, B=5 at edge 10 of a MULT 2×3 → ignored; result 6.
  - `start` at edge 33 → ignored. `start` at edge 34 → accepted.
  - `rst`=0 at edge 20 → `busy`/`done`/`hi`/`lo` all 0, no `done` pulse.
- **WIDTH=8:** MULT 80×80 (−128·−128) → `hi`=40, `lo`=00, `done` after edge 9. DIV 80/FF → `lo`=80, `hi`=00.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the datapath control and the multiply/divide unit.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, A, B, input busy, done, div_zero, hi, lo);
    modport slave  (input start, op, A, B, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: radix-2 Booth multiply, restoring divide.
// All state advances on the falling edge of clk, like the rest of the datapath.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_r;
    logic [WIDTH+1:0] acc;
    logic [WIDTH-1:0] mq;
    logic             qb;
    logic [WIDTH:0]   m;
    logic             a_neg, q_neg, b_zero, u_fix;
    logic             busy_r, done_r, dz_r;
    logic [WIDTH-1:0] hi_r, lo_r;

    logic             sgn, a_ng, b_ng;
    logic [WIDTH-1:0] a_mag, b_mag, rem;
    logic [WIDTH+1:0] m_ext, acc_b, r_dif;
    logic [WIDTH:0]   r_sh;

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;

    always_ff @(negedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = CALC;
            CALC:    if (cnt == LAST) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sgn   = ~bus.op[0];
        a_ng  = sgn & bus.A[WIDTH-1];
        b_ng  = sgn & bus.B[WIDTH-1];
        a_mag = a_ng ? -bus.A : bus.A;
        b_mag = b_ng ? -bus.B : bus.B;
    end

    // acc carries two guard bits so the Booth partial sum never overflows
    always_comb begin
        m_ext = {m[WIDTH], m};
        acc_b = acc;
        case ({mq[0], qb})
            2'b01:   acc_b = acc + m_ext;
            2'b10:   acc_b = acc - m_ext;
            default: acc_b = acc;
        endcase
        r_sh  = {acc[WIDTH-1:0], mq[WIDTH-1]};
        r_dif = {1'b0, r_sh} - {1'b0, m};
        rem   = acc[WIDTH-1:0];
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            op_r   <= '0;
            acc    <= '0;
            mq     <= '0;
            qb     <= 1'b0;
            m      <= '0;
            a_neg  <= 1'b0;
            q_neg  <= 1'b0;
            b_zero <= 1'b0;
            u_fix  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    op_r   <= bus.op;
                    cnt    <= '0;
                    acc    <= '0;
                    qb     <= 1'b0;
                    busy_r <= 1'b1;
                    a_neg  <= a_ng;
                    q_neg  <= (a_ng ^ b_ng) & (|bus.B);
                    b_zero <= ~|bus.B;
                    // MULTU with top multiplier bit set needs the (WIDTH+1)th Booth pair
                    u_fix  <= bus.op[0] & bus.B[WIDTH-1];
                    if (bus.op[1]) begin
                        m  <= {1'b0, b_mag};
                        mq <= a_mag;
                    end else begin
                        m  <= {a_ng, bus.A};
                        mq <= bus.B;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (!op_r[1]) begin
                        {acc, mq, qb} <= {acc_b[WIDTH+1], acc_b, mq};
                    end else if (!r_dif[WIDTH+1]) begin
                        acc <= r_dif;
                        mq  <= {mq[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= {1'b0, r_sh};
                        mq  <= {mq[WIDTH-2:0], 1'b0};
                    end
                end
                FINISH: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    dz_r   <= op_r[1] & b_zero;
                    if (!op_r[1]) begin
                        hi_r <= acc[WIDTH-1:0] + (u_fix ? m[WIDTH-1:0] : '0);
                        lo_r <= mq;
                    end else begin
                        // B==0 leaves |A| as remainder and all-ones quotient, giving hi=A
                        hi_r <= a_neg ? -rem : rem;
                        lo_r <= q_neg ? -mq : mq;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
